// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter feeding a one-entry registered output stage.
// Sources 0..3 (a, b, c, d) offer words under valid/ready; at most one is
// accepted per cycle, and the winner's word and index are held for the consumer.
//
// Output stage states:
//   state | meaning
//   EMPTY | no unconsumed word; out_valid=0, a grant may load the stage
//   FULL  | y/sel hold a word; reloadable only in a cycle where out_ready=1
module mux4_rr_arbiter #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           in_valid,
  output logic [3:0]           in_ready,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic [BUS_WIDTH-1:0] d,
  output logic [BUS_WIDTH-1:0] y,
  output logic [1:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [BUS_WIDTH-1:0] y_q, y_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           last_q, last_d;

  logic                 can_load;
  logic                 grant_any;
  logic [1:0]           grant_idx;
  logic                 accept;
  logic [BUS_WIDTH-1:0] mux_word;

  assign out_valid = (state_q == FULL);
  assign y         = y_q;
  assign sel       = sel_q;

  // The stage can take a new word when empty or when it is being drained this cycle.
  assign can_load = !out_valid || out_ready;

  // Rotating priority search starting just after the most recent winner.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!grant_any && in_valid[last_q + 2'(k)]) begin
        grant_any = 1'b1;
        grant_idx = last_q + 2'(k);
      end
    end
  end

  // Ready is one-hot on the winner, suppressed under reset or a stalled full stage.
  always_comb begin
    in_ready = 4'b0000;
    if (!reset && can_load && grant_any) begin
      in_ready = 4'b0001 << grant_idx;
    end
  end

  assign accept = |(in_valid & in_ready);

  // 4:1 datapath mux steered only by the grant, so unselected sources never reach y.
  always_comb begin
    case (grant_idx)
      2'd0:    mux_word = a;
      2'd1:    mux_word = b;
      2'd2:    mux_word = c;
      default: mux_word = d;
    endcase
  end

  // Next-state for the output stage and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (accept) begin
      y_d    = mux_word;
      sel_d  = grant_idx;
      last_d = grant_idx;
    end
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Register stage; reset drops any buffered word and puts source 0 at top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      y_q     <= '0;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

endmodule
